// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RV32I controller.
// CTRL_UTYPE_EN adds lui/auipc support to the opcode decode helper.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_EXECU,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    function automatic logic op_supported(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: return 1'b1;
`ifdef CTRL_UTYPE_EN
            OP_LUI, OP_AUIPC: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: IR fields and status in, strobes and selects out.
// The controller takes the master side.
interface multicycle_controller_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       RegWrite;
    logic       Retire;
    logic       Illegal;

    modport master (
        input  op, funct3, funct7b5, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, RegWrite, Retire, Illegal
    );

    modport slave (
        output op, funct3, funct7b5, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, RegWrite, Retire, Illegal
    );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode: FSM ALUOp plus funct fields to ALUControl.
// op5 separates R-type (sub allowed) from I-type (funct7b5 is immediate bits).
module alu_decoder
    import ctrl_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [3:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  alucontrol = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing FSM driving the shared ALU, memory port and regfile.
// Define CTRL_UTYPE_EN to decode lui/auipc through the EXECU state.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter bit RESET_PC_HOLD = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus
);

    state_t     state;
    state_t     state_nx;
    logic       settled;
    logic       fetch_go;
    aluop_t     aluop;
    logic [3:0] alucontrol;

    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] immsrc;
    logic       regwrite;
    logic       retire;
    logic       illegal;

    // settled marks the first post-reset cycle as done; only consulted when holding off fetch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            settled <= 1'b0;
        end else begin
            state   <= state_nx;
            settled <= 1'b1;
        end
    end

    assign fetch_go = settled || !RESET_PC_HOLD;

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:    if (fetch_go && bus.MemReady) state_nx = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_nx = S_MEMADR;
                    OP_RTYPE:          state_nx = S_EXECR;
                    OP_ITYPE:          state_nx = S_EXECI;
                    OP_BRANCH:         state_nx = S_BEQ;
                    OP_JAL:            state_nx = S_JAL;
`ifdef CTRL_UTYPE_EN
                    OP_LUI, OP_AUIPC:  state_nx = S_EXECU;
`endif
                    default:           state_nx = S_FETCH;
                endcase
            end
            S_MEMADR:   state_nx = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.MemReady) state_nx = S_MEMWB;
            S_MEMWB:    state_nx = S_FETCH;
            S_MEMWRITE: if (bus.MemReady) state_nx = S_FETCH;
            S_EXECR, S_EXECI, S_EXECU: state_nx = S_ALUWB;
            S_ALUWB:    state_nx = S_FETCH;
            S_BEQ:      state_nx = S_FETCH;
            S_JAL:      state_nx = S_ALUWB;
            default:    state_nx = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite   = 1'b0;
        adrsrc    = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        resultsrc = RES_ALUOUT;
        alusrca   = SRCA_PC;
        alusrcb   = SRCB_RS2;
        immsrc    = IMM_I;
        regwrite  = 1'b0;
        retire    = 1'b0;
        illegal   = 1'b0;
        aluop     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                resultsrc = RES_ALURESULT;
                alusrcb   = SRCB_FOUR;
                if (fetch_go && bus.MemReady) begin
                    pcwrite = 1'b1;
                    irwrite = 1'b1;
                end
            end
            S_DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                immsrc  = IMM_B;
                illegal = !op_supported(bus.op);
            end
            S_MEMADR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                immsrc  = bus.op[5] ? IMM_S : IMM_I;
            end
            S_MEMREAD:  adrsrc = 1'b1;
            S_MEMWB: begin
                resultsrc = RES_DATA;
                regwrite  = 1'b1;
                retire    = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                retire   = bus.MemReady;
            end
            S_EXECR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_RS2;
                aluop   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
            end
`ifdef CTRL_UTYPE_EN
            S_EXECU: begin
                alusrca = bus.op[5] ? SRCA_ZERO : SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                immsrc  = IMM_U;
            end
`endif
            S_ALUWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            S_BEQ: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_RS2;
                aluop   = ALUOP_SUB;
                // funct3[0] inverts the sense: beq on Zero, bne on !Zero
                if (bus.funct3[2:1] == 2'b00) begin
                    pcwrite = bus.Zero ^ bus.funct3[0];
                    retire  = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            S_JAL: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_FOUR;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            pcwrite   = 1'b0;
            adrsrc    = 1'b0;
            memwrite  = 1'b0;
            irwrite   = 1'b0;
            resultsrc = '0;
            alusrca   = '0;
            alusrcb   = '0;
            immsrc    = '0;
            regwrite  = 1'b0;
            retire    = 1'b0;
            illegal   = 1'b0;
            aluop     = ALUOP_ADD;
        end
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (bus.funct3),
        .funct7b5   (bus.funct7b5),
        .op5        (bus.op[5]),
        .alucontrol (alucontrol)
    );

    assign bus.PCWrite    = pcwrite;
    assign bus.AdrSrc     = adrsrc;
    assign bus.MemWrite   = memwrite;
    assign bus.IRWrite    = irwrite;
    assign bus.ResultSrc  = resultsrc;
    assign bus.ALUSrcA    = alusrca;
    assign bus.ALUSrcB    = alusrcb;
    assign bus.ImmSrc     = immsrc;
    assign bus.ALUControl = alucontrol;
    assign bus.RegWrite   = regwrite;
    assign bus.Retire     = retire;
    assign bus.Illegal    = illegal;

endmodule
